hdmi_packet_scheduler: RTL and testbench

Parametrised data-island packet scheduler for the HDMI transmitter, in the `clk_pixel` domain. It sits between the audio sample source, the ACR generator and the packet assembler. It buffers multi-channel audio samples in an internal FIFO and selects one packet type per data-island window. Selection priority is ACR, then audio sample, then per-field InfoFrames, then Null. It supports 2-channel (layout 0) and 8-channel (layout 1) audio, partial sample packets and a configurable InfoFrame repeat period.

---
 rtl/hdmi_packet_pkg.sv | 27 ++
 rtl/audio_sample_fifo.sv | 48 ++++
 rtl/hdmi_packet_scheduler.sv | 133 +++++++++++++
 tb/tb_hdmi_packet_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_packet_pkg.sv
// Shared constants and types for the HDMI data-island packet scheduler.
package hdmi_packet_pkg;

  localparam logic [7:0] PKT_NULL = 8'h00;
  localparam logic [7:0] PKT_ACR  = 8'h01;
  localparam logic [7:0] PKT_ASP  = 8'h02;
  localparam logic [7:0] PKT_AVI  = 8'h82;
  localparam logic [7:0] PKT_SPD  = 8'h83;
  localparam logic [7:0] PKT_AIF  = 8'h84;

  localparam int FRAMES_PER_BLOCK = 192;

  typedef enum logic {
    LAYOUT_2CH = 1'b0,
    LAYOUT_8CH = 1'b1
  } asp_layout_e;

  typedef logic [23:0] sample24_t;

  // IEC 60958 frame index advance, wrapping at the block boundary
  function automatic logic [7:0] frame_add(logic [7:0] fc, logic [2:0] n);
    logic [8:0] sum;
    sum = {1'b0, fc} + {6'd0, n};
    return (sum >= 9'(FRAMES_PER_BLOCK)) ? 8'(sum - 9'(FRAMES_PER_BLOCK)) : sum[7:0];
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Audio sample FIFO: one entry per multi-channel sample, up to four pops per cycle.
module audio_sample_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                        clk_pixel,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [2:0]                  pop_count,
  output logic [3:0][WIDTH-1:0]       rd_data,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;

  // full is taken from the pre-edge occupancy, so a same-cycle pop never admits a push
  assign full    = (occupancy == OW'(DEPTH));
  assign do_push = push && !full;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_ptr + AW'(pop_count);
      occupancy <= occupancy + OW'(do_push) - OW'(pop_count);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (do_push && !reset) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) rd_data[k] = mem[rd_ptr + AW'(k)];
  end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// Data-island packet arbiter: ACR, audio samples, per-field InfoFrames, Null.
module hdmi_packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH  = 16,
  parameter int AUDIO_CHANNELS   = 2,
  parameter int FIFO_DEPTH       = 8,
  parameter int INFOFRAME_PERIOD = 1
) (
  input  logic                                      clk_pixel,
  input  logic                                      reset,
  input  logic                                      video_field_end,
  input  logic                                      packet_enable,
  input  logic [4:0]                                packet_pixel_counter,
  input  logic                                      acr_request,
  input  logic                                      sample_valid,
  output logic                                      sample_ready,
  input  logic [AUDIO_CHANNELS*AUDIO_BIT_WIDTH-1:0] sample_data,
  output logic [7:0]                                packet_type,
  output logic [191:0]                              asp_words,
  output logic [3:0]                                asp_present,
  output logic                                      asp_layout,
  output logic [7:0]                                frame_counter,
  output logic                                      overflow
);

  localparam int W   = AUDIO_CHANNELS * 24;
  localparam int PAD = 24 - AUDIO_BIT_WIDTH;
  localparam int OW  = $clog2(FIFO_DEPTH) + 1;
  localparam asp_layout_e LAYOUT = (AUDIO_CHANNELS == 8) ? LAYOUT_8CH : LAYOUT_2CH;

  if (!(AUDIO_CHANNELS == 2 || AUDIO_CHANNELS == 8) || AUDIO_BIT_WIDTH < 16 ||
      AUDIO_BIT_WIDTH > 24 || INFOFRAME_PERIOD < 1 || INFOFRAME_PERIOD > 2) begin : g_bad_param
    $error("hdmi_packet_scheduler: unsupported parameter combination");
  end

  logic [W-1:0]        wr_data;
  logic [3:0][W-1:0]   rd_data;
  logic [2:0]          pop_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [OW-1:0]       occupancy;
  logic [2:0]          avail_n;
  logic [191:0]        asp_next;
  logic [3:0]          present_next;
  logic [7:0]          type_next;
  logic [2:0]          mark_sent;
  logic [2:0]          if_sent;
  logic [1:0]          field_cnt;
  logic [2:0]          asp_count;
  logic                acr_pending;
  logic                field_wrap;

  for (genvar c = 0; c < AUDIO_CHANNELS; c++) begin : g_pack
    assign wr_data[c*24 +: 24] =
      sample24_t'(sample_data[c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]) << PAD;
  end

  audio_sample_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .push      (sample_valid),
    .wr_data   (wr_data),
    .pop_count (pop_count),
    .rd_data   (rd_data),
    .full      (fifo_full),
    .occupancy (occupancy)
  );

  assign fifo_empty   = (occupancy == '0);
  assign sample_ready = !fifo_full;
  assign asp_layout   = LAYOUT;

  // Layout 0 packs up to four 2-channel samples; layout 1 spreads one 8-channel sample
  if (AUDIO_CHANNELS == 2) begin : g_layout0
    assign avail_n = (occupancy >= OW'(4)) ? 3'd4 : 3'(occupancy);
    for (genvar k = 0; k < 4; k++) begin : g_sub
      assign asp_next[k*48 +: 48] = (3'(k) < avail_n) ? rd_data[k] : '0;
    end
    assign present_next = 4'((5'd1 << avail_n) - 5'd1);
  end else begin : g_layout1
    assign avail_n      = fifo_empty ? 3'd0 : 3'd1;
    assign asp_next     = rd_data[0];
    assign present_next = 4'b1111;
  end

  always_comb begin
    type_next = PKT_NULL;
    mark_sent = '0;
    if (acr_pending)      type_next = PKT_ACR;
    else if (!fifo_empty) type_next = PKT_ASP;
    else if (!if_sent[0]) begin type_next = PKT_AIF; mark_sent = 3'b001; end
    else if (!if_sent[1]) begin type_next = PKT_AVI; mark_sent = 3'b010; end
    else if (!if_sent[2]) begin type_next = PKT_SPD; mark_sent = 3'b100; end
    pop_count = (packet_enable && type_next == PKT_ASP) ? avail_n : 3'd0;
  end

  assign field_wrap = video_field_end && (field_cnt == 2'(INFOFRAME_PERIOD - 1));

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      packet_type   <= PKT_NULL;
      asp_words     <= '0;
      asp_present   <= '0;
      asp_count     <= '0;
      frame_counter <= '0;
      overflow      <= 1'b0;
      acr_pending   <= 1'b0;
      if_sent       <= '0;
      field_cnt     <= '0;
    end else begin
      if (sample_valid && !sample_ready) overflow <= 1'b1;
      // a fresh request wins over the clear from this window's ACR selection
      acr_pending <= acr_request || (acr_pending && !packet_enable);
      if (packet_pixel_counter == 5'd31 && packet_type == PKT_ASP)
        frame_counter <= frame_add(frame_counter, asp_count);
      if (packet_enable) begin
        packet_type <= type_next;
        asp_words   <= (type_next == PKT_ASP) ? asp_next : '0;
        asp_present <= (type_next == PKT_ASP) ? present_next : '0;
        if (type_next == PKT_ASP) asp_count <= avail_n;
      end
      if (field_wrap) begin
        if_sent   <= '0;
        field_cnt <= '0;
      end else begin
        if (packet_enable) if_sent <= if_sent | mark_sent;
        if (video_field_end) field_cnt <= field_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Scoreboard bench: a 2-channel and an 8-channel scheduler against a queue-based reference model.
module tb_hdmi_packet_scheduler;

  localparam logic [7:0] T_NULL = 8'h00;
  localparam logic [7:0] T_ACR  = 8'h01;
  localparam logic [7:0] T_ASP  = 8'h02;
  localparam logic [7:0] T_AVI  = 8'h82;
  localparam logic [7:0] T_SPD  = 8'h83;
  localparam logic [7:0] T_AIF  = 8'h84;

  logic clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  logic         reset, video_field_end, packet_enable, acr_request;
  logic [4:0]   packet_pixel_counter;
  logic         sv2, sv8;
  logic [31:0]  sd2;
  logic [191:0] sd8;

  logic         a_rdy    [2];
  logic [7:0]   a_type   [2];
  logic [191:0] a_words  [2];
  logic [3:0]   a_pres   [2];
  logic         a_layout [2];
  logic [7:0]   a_fc     [2];
  logic         a_ovf    [2];

  hdmi_packet_scheduler #(.AUDIO_BIT_WIDTH(16), .AUDIO_CHANNELS(2),
                          .FIFO_DEPTH(8), .INFOFRAME_PERIOD(1)) u_dut2 (
    .clk_pixel(clk_pixel), .reset(reset), .video_field_end(video_field_end),
    .packet_enable(packet_enable), .packet_pixel_counter(packet_pixel_counter),
    .acr_request(acr_request), .sample_valid(sv2), .sample_ready(a_rdy[0]),
    .sample_data(sd2), .packet_type(a_type[0]), .asp_words(a_words[0]),
    .asp_present(a_pres[0]), .asp_layout(a_layout[0]), .frame_counter(a_fc[0]),
    .overflow(a_ovf[0]));

  hdmi_packet_scheduler #(.AUDIO_BIT_WIDTH(24), .AUDIO_CHANNELS(8),
                          .FIFO_DEPTH(8), .INFOFRAME_PERIOD(2)) u_dut8 (
    .clk_pixel(clk_pixel), .reset(reset), .video_field_end(video_field_end),
    .packet_enable(packet_enable), .packet_pixel_counter(packet_pixel_counter),
    .acr_request(acr_request), .sample_valid(sv8), .sample_ready(a_rdy[1]),
    .sample_data(sd8), .packet_type(a_type[1]), .asp_words(a_words[1]),
    .asp_present(a_pres[1]), .asp_layout(a_layout[1]), .frame_counter(a_fc[1]),
    .overflow(a_ovf[1]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int d, input logic [191:0] act,
                     input logic [191:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", name, d, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic         chk_pkt;
    logic [7:0]   typ;
    logic [191:0] words;
    logic [3:0]   pres;
    logic [7:0]   fc;
    logic         rdy;
    logic         ovf;
  } exp_t;

  exp_t         expq [$];
  logic [191:0] fq0 [$];
  logic [191:0] fq1 [$];
  logic [7:0]   if_order [3] = '{T_AIF, T_AVI, T_SPD};
  int           period   [2] = '{1, 2};

  logic         m_acr   [2];
  logic         m_sent  [2][3];
  int           m_field [2];
  int           m_fc    [2];
  int           m_n     [2];
  logic [7:0]   m_type  [2];
  logic [191:0] m_words [2];
  logic [3:0]   m_pres  [2];
  logic         m_ovf   [2];

  function automatic int fsize(int d);
    return (d == 0) ? fq0.size() : fq1.size();
  endfunction

  function automatic logic [191:0] fpop(int d);
    if (d == 0) return fq0.pop_front();
    return fq1.pop_front();
  endfunction

  function automatic logic [191:0] expand2(logic [31:0] s);
    logic [191:0] r;
    r = '0;
    r[23:0]  = {s[15:0], 8'h00};
    r[47:24] = {s[31:16], 8'h00};
    return r;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      exp_t         e;
      int           occ, n;
      logic         sv, acr_sel, picked;
      logic [191:0] samp, tmp;
      sv   = (d == 0) ? sv2 : sv8;
      samp = (d == 0) ? expand2(sd2) : sd8;
      e.chk_pkt = 1'b0;
      if (reset) begin
        if (d == 0) fq0.delete(); else fq1.delete();
        m_acr[d] = 0; m_field[d] = 0; m_fc[d] = 0; m_n[d] = 0;
        for (int i = 0; i < 3; i++) m_sent[d][i] = 0;
        m_type[d] = T_NULL; m_words[d] = '0; m_pres[d] = '0; m_ovf[d] = 0;
        e.chk_pkt = 1'b1;
      end else begin
        occ = fsize(d);
        acr_sel = 0;
        if (sv && occ == 8) m_ovf[d] = 1;
        if (packet_pixel_counter == 5'd31 && m_type[d] == T_ASP)
          m_fc[d] = (m_fc[d] + m_n[d]) % 192;
        if (packet_enable) begin
          e.chk_pkt = 1'b1;
          m_words[d] = '0;
          m_pres[d]  = '0;
          if (m_acr[d]) begin
            m_type[d] = T_ACR;
            acr_sel = 1;
          end else if (occ > 0) begin
            m_type[d] = T_ASP;
            if (d == 0) begin
              n = (occ < 4) ? occ : 4;
              for (int k = 0; k < n; k++) begin
                tmp = fpop(0);
                m_words[d][k*48 +: 48] = tmp[47:0];
                m_pres[d][k] = 1'b1;
              end
            end else begin
              n = 1;
              m_words[d] = fpop(1);
              m_pres[d] = 4'hF;
            end
            m_n[d] = n;
          end else begin
            m_type[d] = T_NULL;
            picked = 0;
            for (int i = 0; i < 3; i++) begin
              if (!picked && !m_sent[d][i]) begin
                m_type[d] = if_order[i];
                m_sent[d][i] = 1;
                picked = 1;
              end
            end
          end
        end
        if (acr_request) m_acr[d] = 1;
        else if (acr_sel) m_acr[d] = 0;
        if (video_field_end) begin
          m_field[d]++;
          if (m_field[d] == period[d]) begin
            m_field[d] = 0;
            for (int i = 0; i < 3; i++) m_sent[d][i] = 0;
          end
        end
        if (sv && occ < 8) begin
          if (d == 0) fq0.push_back(samp); else fq1.push_back(samp);
        end
      end
      e.typ   = m_type[d];
      e.words = m_words[d];
      e.pres  = m_pres[d];
      e.fc    = 8'(m_fc[d]);
      e.rdy   = (fsize(d) < 8);
      e.ovf   = m_ovf[d];
      expq.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(posedge clk_pixel);
    #2;
    if (expq.size() >= 2) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        e = expq.pop_front();
        chk("frame_counter", d, 192'(a_fc[d]), 192'(e.fc));
        chk("sample_ready", d, 192'(a_rdy[d]), 192'(e.rdy));
        chk("overflow", d, 192'(a_ovf[d]), 192'(e.ovf));
        if (e.chk_pkt) begin
          chk("packet_type", d, 192'(a_type[d]), 192'(e.typ));
          chk("asp_words", d, a_words[d], e.words);
          chk("asp_present", d, 192'(a_pres[d]), 192'(e.pres));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cycle();
    model_step();
    @(posedge clk_pixel);
    #1;
    reset = 0; video_field_end = 0; packet_enable = 0; acr_request = 0;
    sv2 = 0; sv8 = 0; packet_pixel_counter = 5'd0;
  endtask

  task automatic do_reset();
    reset = 1; cycle();
    reset = 1; cycle();
  endtask

  task automatic enable();
    packet_enable = 1; cycle();
  endtask

  task automatic push2(input logic [31:0] v);
    sv2 = 1; sd2 = v; cycle();
  endtask

  task automatic pix31();
    packet_pixel_counter = 5'd31; cycle();
  endtask

  logic [7:0] seq [7] = '{T_AIF, T_AVI, T_SPD, T_NULL, T_AIF, T_AVI, T_SPD};

  initial begin
    reset = 1; video_field_end = 0; packet_enable = 0; acr_request = 0;
    packet_pixel_counter = 0; sv2 = 0; sv8 = 0; sd2 = '0; sd8 = '0;
    do_reset();
    chk("reset_type", 0, 192'(a_type[0]), 192'(T_NULL));
    chk("reset_ready", 0, 192'(a_rdy[0]), 192'(1'b1));
    chk("layout0", 0, 192'(a_layout[0]), 192'(1'b0));
    chk("layout1", 1, 192'(a_layout[1]), 192'(1'b1));

    // InfoFrame rotation with no audio, then one field end
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin video_field_end = 1; cycle(); end
      enable();
      chk("if_sequence", 0, 192'(a_type[0]), 192'(seq[i]));
    end

    // layout 0: six samples -> 4 + 2
    do_reset();
    for (int i = 0; i < 6; i++) push2($urandom);
    enable();
    chk("asp_type", 0, 192'(a_type[0]), 192'(T_ASP));
    chk("asp_present4", 0, 192'(a_pres[0]), 192'(4'b1111));
    chk("fc_start", 0, 192'(a_fc[0]), 192'(0));
    pix31();
    chk("fc_after4", 0, 192'(a_fc[0]), 192'(4));
    enable();
    chk("asp_present2", 0, 192'(a_pres[0]), 192'(4'b0011));
    pix31();
    chk("fc_after6", 0, 192'(a_fc[0]), 192'(6));

    // layout 1: channel c = C0000 + c
    do_reset();
    for (int c = 0; c < 8; c++) sd8[c*24 +: 24] = 24'hC0000 + 24'(c);
    sv8 = 1; cycle();
    enable();
    chk("l1_sub2_ch1", 1, 192'(a_words[1][120 +: 24]), 192'(24'hC0005));

    // ACR priority and re-request during selection
    do_reset();
    acr_request = 1; cycle();
    push2($urandom);
    enable();
    chk("acr_first", 0, 192'(a_type[0]), 192'(T_ACR));
    enable();
    chk("asp_after_acr", 0, 192'(a_type[0]), 192'(T_ASP));
    acr_request = 1; cycle();
    acr_request = 1; enable();
    chk("acr_coincide", 0, 192'(a_type[0]), 192'(T_ACR));
    enable();
    chk("acr_again", 0, 192'(a_type[0]), 192'(T_ACR));

    // overflow on a full FIFO
    do_reset();
    for (int i = 0; i < 9; i++) push2(32'h1000_0001 * (i + 1));
    chk("ovf_set", 0, 192'(a_ovf[0]), 192'(1'b1));
    chk("ovf_ready", 0, 192'(a_rdy[0]), 192'(1'b0));
    enable();
    enable();
    enable();
    chk("ovf_drained", 0, 192'(a_type[0]), 192'(T_AIF));

    // frame counter block wrap
    do_reset();
    for (int i = 1; i <= 48; i++) begin
      for (int j = 0; j < 4; j++) push2($urandom);
      enable();
      pix31();
      if (i == 47) chk("fc_188", 0, 192'(a_fc[0]), 192'(188));
      if (i == 48) chk("fc_wrap", 0, 192'(a_fc[0]), 192'(0));
    end

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset           = ($urandom_range(0, 599) == 0);
      video_field_end = ($urandom_range(0, 39) == 0);
      packet_enable   = ($urandom_range(0, 5) == 0);
      acr_request     = ($urandom_range(0, 24) == 0);
      packet_pixel_counter = 5'($urandom_range(0, 31));
      sv2 = ((i / 500) % 2 == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      sv8 = ($urandom_range(0, 2) == 0);
      sd2 = $urandom;
      for (int c = 0; c < 8; c++) sd8[c*24 +: 24] = 24'($urandom);
      cycle();
    end

    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
